uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// Define UART_ARB_LOCK_EN to add a per-requester lock input that keeps the grant for multi-byte packets.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int GAP_CLKS     = 868,
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]     lock,
`endif
    output logic [N_REQ-1:0]     ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 active,
    output logic                 timeout_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0] GAP_LAST = (GAP_CLKS > 0) ? 16'(GAP_CLKS - 1) : 16'd0;
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t            state_reg, state_next;
    logic [15:0]       to_cnt_reg, to_cnt_next;
    logic [15:0]       gap_cnt_reg, gap_cnt_next;
    logic [IW-1:0]     last_grant_reg, last_grant_next;
    logic [IW-1:0]     grant_reg, grant_next;
    logic [N_REQ-1:0]  ack_reg, ack_next;
    logic              tx_start_reg, tx_start_next;
    logic [7:0]        tx_data_reg, tx_data_next;
    logic              timeout_reg, timeout_next;
    logic              hold_reg, hold_next;

    logic [7:0]        byte_arr [N_REQ];
    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     cand;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic              lock_hit;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
            assign byte_arr[gi] = req_data[8*gi +: 8];
        end
    endgenerate

`ifdef UART_ARB_LOCK_EN
    assign lock_hit = lock[grant_reg] & req[grant_reg];
`else
    assign lock_hit = 1'b0;
`endif

    // First requester found when walking forward from the one after last_grant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last_grant_reg) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign pick_found = (hold_reg && req[grant_reg]) || win_found;
    assign pick_idx   = (hold_reg && req[grant_reg]) ? grant_reg : win_idx;

    always_comb begin
        state_next      = state_reg;
        to_cnt_next     = to_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        last_grant_next = last_grant_reg;
        grant_next      = grant_reg;
        ack_next        = '0;
        tx_start_next   = tx_start_reg;
        tx_data_next    = tx_data_reg;
        timeout_next    = 1'b0;
        hold_next       = hold_reg;
        case (state_reg)
            IDLE: begin
                hold_next = 1'b0;
                if (pick_found) begin
                    tx_data_next    = byte_arr[pick_idx];
                    grant_next      = pick_idx;
                    last_grant_next = pick_idx;
                    ack_next        = N_REQ'(1) << pick_idx;
                    tx_start_next   = 1'b1;
                    to_cnt_next     = '0;
                    state_next      = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    tx_start_next = 1'b0;
                    to_cnt_next   = '0;
                    state_next    = WAIT_DONE;
                end else if (to_cnt_reg == TO_LAST) begin
                    tx_start_next = 1'b0;
                    to_cnt_next   = '0;
                    timeout_next  = 1'b1;
                    state_next    = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    gap_cnt_next = '0;
                    if (GAP_CLKS == 0) begin
                        hold_next  = lock_hit;
                        state_next = IDLE;
                    end else begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    hold_next  = lock_hit;
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            to_cnt_reg     <= '0;
            gap_cnt_reg    <= '0;
            last_grant_reg <= IW'(N_REQ - 1);
            grant_reg      <= '0;
            ack_reg        <= '0;
            tx_start_reg   <= 1'b0;
            tx_data_reg    <= '0;
            timeout_reg    <= 1'b0;
            hold_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            to_cnt_reg     <= to_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            ack_reg        <= ack_next;
            tx_start_reg   <= tx_start_next;
            tx_data_reg    <= tx_data_next;
            timeout_reg    <= timeout_next;
            hold_reg       <= hold_next;
        end
    end

    assign ack         = ack_reg;
    assign tx_start    = tx_start_reg;
    assign tx_data     = tx_data_reg;
    assign grant_id    = 3'(grant_reg);
    assign active      = (state_reg != IDLE);
    assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected grants, a monitor checks every ack pulse.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
`ifdef UART_ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [2:0]  grant_id;
    logic        active;
    logic        timeout_err;
    logic        model_en;

    int total = 0;
    int bad = 0;
    int ack_seen = 0;

    typedef struct packed {
        logic [3:0] ack;
        logic [2:0] gid;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .GAP_CLKS(4), .TIMEOUT_CLKS(16)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
`ifdef UART_ARB_LOCK_EN
        .lock(lock),
`endif
        .ack(ack),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .active(active),
        .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req_v);
        end
    endtask

    // Transmitter model: busy rises 2 clocks after tx_start is seen, stays high 20 clocks.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (model_en && tx_start === 1'b1 && !tx_busy) begin
                repeat (2) @(posedge clk);
                #1;
                tx_busy = 1'b1;
                repeat (20) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    // Monitor: every ack pulse is matched against the next queued grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && ack !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_ack", 32'(ack), 32'(e.ack));
                    check("mon_grant_id", 32'(grant_id), 32'(e.gid));
                    check("mon_tx_data", 32'(tx_data), 32'(e.data));
                    check("mon_tx_start", 32'(tx_start), 32'h1);
                    $display("grant ack=%b id=%0d data=%02h", ack, grant_id, tx_data);
                end
                ack_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int n = 0;
        while (tx_busy !== lvl && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(tx_busy), 32'(lvl));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (active !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        check(name, 32'(active), 32'h0);
    endtask

    task automatic wait_acks(input int target, input string name);
        int n = 0;
        while (ack_seen < target && n < 800) begin
            tick();
            n++;
        end
        check(name, 32'(ack_seen), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'h0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'h0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'h0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'h0);
        check({tag, "_active"}, 32'(active), 32'h0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    initial begin
        int hi_cnt;
        int to_pulses;
        int target;
        rst = 1'b1;
        req = 4'b0000;
        req_data = 32'h0;
        model_en = 1'b1;
`ifdef UART_ARB_LOCK_EN
        lock = 4'b0000;
`endif
        repeat (2) tick();
        check_reset_outputs("rst");
        rst = 1'b0;

        // Single request, byte 2 = A5
        req_data = 32'h00A5_0000;
        exp_q.push_back('{4'b0100, 3'd2, 8'hA5});
        req = 4'b0100;
        tick();
        req = 4'b0000;
        check("s1_latency_ack", 32'(ack), 32'h4);
        check("s1_latency_start", 32'(tx_start), 32'h1);
        wait_busy(1'b1, "s1_busy_rise");
        check("s1_start_held", 32'(tx_start), 32'h1);
        tick();
        check("s1_start_drop", 32'(tx_start), 32'h0);
        wait_busy(1'b0, "s1_busy_fall");
        repeat (4) tick();
        check("s1_gap_active", 32'(active), 32'h1);
        tick();
        check("s1_back_idle", 32'(active), 32'h0);

        // All four requesting: strict rotation from requester 0
        do_reset();
        req_data = 32'h1312_1110;
        exp_q.push_back('{4'b0001, 3'd0, 8'h10});
        exp_q.push_back('{4'b0010, 3'd1, 8'h11});
        exp_q.push_back('{4'b0100, 3'd2, 8'h12});
        exp_q.push_back('{4'b1000, 3'd3, 8'h13});
        exp_q.push_back('{4'b0001, 3'd0, 8'h10});
        target = ack_seen + 5;
        req = 4'b1111;
        wait_acks(target, "s2_five_grants");
        req = 4'b0000;
        wait_idle("s2_idle");

        // Transmitter never answers: launch timeout
        do_reset();
        model_en = 1'b0;
        req_data = 32'h0000_C35A;
        exp_q.push_back('{4'b0001, 3'd0, 8'h5A});
        req = 4'b0001;
        hi_cnt = 0;
        to_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) req = 4'b0000;
            if (tx_start === 1'b1) hi_cnt++;
            if (timeout_err === 1'b1) to_pulses++;
        end
        check("s3_start_cycles", 32'(hi_cnt), 32'd16);
        check("s3_timeout_pulses", 32'(to_pulses), 32'd1);
        check("s3_idle", 32'(active), 32'h0);
        exp_q.push_back('{4'b0010, 3'd1, 8'hC3});
        req = 4'b0011;
        tick();
        req = 4'b0000;
        check("s3_next_grant", 32'(grant_id), 32'd1);
        wait_idle("s3_idle2");
        model_en = 1'b1;

        // Reset in the middle of a frame
        do_reset();
        req_data = 32'h7E00_0031;
        exp_q.push_back('{4'b0001, 3'd0, 8'h31});
        req = 4'b0001;
        tick();
        req = 4'b0000;
        wait_busy(1'b1, "s4_busy_rise");
        repeat (3) tick();
        check("s4_in_frame", 32'(active), 32'h1);
        rst = 1'b1;
        tick();
        check_reset_outputs("s4_rst");
        rst = 1'b0;
        wait_busy(1'b0, "s4_busy_fall");
        exp_q.push_back('{4'b1000, 3'd3, 8'h7E});
        req = 4'b1000;
        tick();
        req = 4'b0000;
        check("s4_latency_ack", 32'(ack), 32'h8);
        check("s4_latency_start", 32'(tx_start), 32'h1);
        wait_idle("s4_idle");
        do_reset();
        exp_q.push_back('{4'b0001, 3'd0, 8'h31});
        req = 4'b1001;
        tick();
        req = 4'b0000;
        check("s4_prio_after_reset", 32'(grant_id), 32'd0);
        wait_idle("s4_idle2");

`ifdef UART_ARB_LOCK_EN
        // Lock keeps requester 0 for three frames, then rotation resumes
        do_reset();
        req_data = 32'h0000_B2B1;
        exp_q.push_back('{4'b0001, 3'd0, 8'hB1});
        exp_q.push_back('{4'b0001, 3'd0, 8'hB1});
        exp_q.push_back('{4'b0001, 3'd0, 8'hB1});
        exp_q.push_back('{4'b0010, 3'd1, 8'hB2});
        lock = 4'b0001;
        req = 4'b0011;
        target = ack_seen + 3;
        wait_acks(target, "s5_locked_grants");
        lock = 4'b0000;
        wait_acks(target + 1, "s5_unlocked_grant");
        req = 4'b0000;
        wait_idle("s5_idle");
`endif

        repeat (5) tick();
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
